dm12x8_buf: RTL and testbench

- Buffered 1-to-2 demultiplexer for 8-bit flits with valid/ready handshakes on every side.
- Steers each accepted input word to branch A (sel=0) or branch B (sel=1).
- Each branch has its own small FIFO, so a stalled branch never blocks traffic already queued in the other.
- Sits on the split side of the datapath, the counterpart of the 2:1 merge primitives, for fanning a stream out to two consumers.

---
 rtl/dm12x8_buf.sv | 122 ++++++++++++
 tb/tb_dm12x8_buf.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm12x8_buf.sv
// Buffered 1:2 demux for valid/ready flits: one FIFO per branch, one edge from input to branch head, no in-to-out comb path.
// in_ready reflects only the selected branch's fullness; a stalled branch never blocks the other.

module dm12x8_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o,
    output logic [CW-1:0]    count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign vld_o   = (cnt_q != '0);
    assign count_o = cnt_q;
    assign dat_o   = vld_o ? mem_q[rd_ptr_q] : '0;

    // Full refuses a push even when a pop happens the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & vld_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end
endmodule

module dm12x8_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             a_valid,
    output logic [WIDTH-1:0] a_data,
    input  logic             a_ready,
    output logic [CW-1:0]    a_count,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data,
    input  logic             b_ready,
    output logic [CW-1:0]    b_count
);
    logic a_full, b_full;
    logic push_a, push_b;

    assign in_ready = in_sel ? ~b_full : ~a_full;
    assign push_a   = in_valid & in_ready & ~in_sel;
    assign push_b   = in_valid & in_ready &  in_sel;

    dm12x8_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push_a),
        .push_dat_i (in_data),
        .pop_i      (a_ready),
        .full_o     (a_full),
        .vld_o      (a_valid),
        .dat_o      (a_data),
        .count_o    (a_count)
    );

    dm12x8_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push_b),
        .push_dat_i (in_data),
        .pop_i      (b_ready),
        .full_o     (b_full),
        .vld_o      (b_valid),
        .dat_o      (b_data),
        .count_o    (b_count)
    );
endmodule

// File: tb/tb_dm12x8_buf.sv
// Bench for dm12x8_buf: fixed vector table, hand-written corner sequences, and a randomized run against a queue model.

module tb_dm12x8_buf;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid, in_sel, in_ready;
    logic [WIDTH-1:0] in_data;
    logic             a_valid, a_ready, b_valid, b_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic [CW-1:0]    a_count, b_count;

    always #5 clk = ~clk;

    dm12x8_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .in_ready (in_ready),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .a_count  (a_count),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .b_count  (b_count)
    );

    typedef struct packed {
        logic       v;
        logic       sel;
        logic [7:0] d;
        logic       ar;
        logic       br;
        logic       e_rdy;
        logic       e_av;
        logic [7:0] e_ad;
        logic [1:0] e_ac;
        logic       e_bv;
        logic [7:0] e_bd;
        logic [1:0] e_bc;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    vec_t       vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic s, input logic [7:0] d, input logic ar, input logic br);
        @(negedge clk);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
    endtask

    // Advance the queue model by one edge, then let the DUT take the same edge.
    task automatic tick();
        bit push, pa, pb;
        push = in_valid && (in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
        pa   = (qa.size() != 0) && a_ready;
        pb   = (qb.size() != 0) && b_ready;
        if (pa) void'(qa.pop_front());
        if (pb) void'(qb.pop_front());
        if (push) begin
            if (in_sel) qb.push_back(in_data);
            else        qa.push_back(in_data);
        end
        @(posedge clk);
    endtask

    task automatic check_model(input string tag);
        logic [7:0] ea, eb;
        ea = (qa.size() != 0) ? qa[0] : 8'h00;
        eb = (qb.size() != 0) ? qb[0] : 8'h00;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH)));
        check({tag, ".a_valid"},  32'(a_valid),  32'(qa.size() != 0));
        check({tag, ".a_data"},   32'(a_data),   32'(ea));
        check({tag, ".a_count"},  32'(a_count),  32'(qa.size()));
        check({tag, ".b_valid"},  32'(b_valid),  32'(qb.size() != 0));
        check({tag, ".b_data"},   32'(b_data),   32'(eb));
        check({tag, ".b_count"},  32'(b_count),  32'(qb.size()));
    endtask

    function automatic vec_t mk(input logic v, input logic s, input logic [7:0] d, input logic ar, input logic br,
                                input logic er, input logic eav, input logic [7:0] ead, input logic [1:0] eac,
                                input logic ebv, input logic [7:0] ebd, input logic [1:0] ebc);
        return '{v, s, d, ar, br, er, eav, ead, eac, ebv, ebd, ebc};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       hv, hs, last_rdy;
        logic [7:0] hd;
        logic [7:0] rx[$];
        int         idx, cyc;
        logic       brt;

        // Single steer, fill/back-pressure with sel switch, full with simultaneous pop.
        vecs[0]  = mk(1'b1, 1'b0, 8'h3C, 1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 2'd0,  1'b0, 8'h00, 2'd0);
        vecs[1]  = mk(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1,  1'b1, 1'b1, 8'h3C, 2'd1,  1'b0, 8'h00, 2'd0);
        vecs[2]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 2'd0,  1'b1, 8'hA5, 2'd1);
        vecs[3]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 2'd0,  1'b0, 8'h00, 2'd0);
        vecs[4]  = mk(1'b1, 1'b0, 8'h01, 1'b0, 1'b1,  1'b1, 1'b0, 8'h00, 2'd0,  1'b0, 8'h00, 2'd0);
        vecs[5]  = mk(1'b1, 1'b0, 8'h02, 1'b0, 1'b1,  1'b1, 1'b1, 8'h01, 2'd1,  1'b0, 8'h00, 2'd0);
        vecs[6]  = mk(1'b1, 1'b0, 8'h03, 1'b0, 1'b1,  1'b0, 1'b1, 8'h01, 2'd2,  1'b0, 8'h00, 2'd0);
        vecs[7]  = mk(1'b1, 1'b0, 8'h03, 1'b0, 1'b1,  1'b0, 1'b1, 8'h01, 2'd2,  1'b0, 8'h00, 2'd0);
        vecs[8]  = mk(1'b1, 1'b1, 8'h03, 1'b0, 1'b1,  1'b1, 1'b1, 8'h01, 2'd2,  1'b0, 8'h00, 2'd0);
        vecs[9]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1,  1'b0, 1'b1, 8'h01, 2'd2,  1'b1, 8'h03, 2'd1);
        vecs[10] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1,  1'b1, 1'b1, 8'h02, 2'd1,  1'b0, 8'h00, 2'd0);
        vecs[11] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 2'd0,  1'b0, 8'h00, 2'd0);
        vecs[12] = mk(1'b1, 1'b0, 8'h10, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 2'd0,  1'b0, 8'h00, 2'd0);
        vecs[13] = mk(1'b1, 1'b0, 8'h11, 1'b0, 1'b0,  1'b1, 1'b1, 8'h10, 2'd1,  1'b0, 8'h00, 2'd0);
        vecs[14] = mk(1'b1, 1'b0, 8'h12, 1'b1, 1'b0,  1'b0, 1'b1, 8'h10, 2'd2,  1'b0, 8'h00, 2'd0);
        vecs[15] = mk(1'b1, 1'b0, 8'h12, 1'b1, 1'b0,  1'b1, 1'b1, 8'h11, 2'd1,  1'b0, 8'h00, 2'd0);
        vecs[16] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 1'b1, 8'h12, 2'd1,  1'b0, 8'h00, 2'd0);
        vecs[17] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 1'b0, 8'h00, 2'd0,  1'b0, 8'h00, 2'd0);

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = 8'h00;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.a_valid",  32'(a_valid),  32'd0);
        check("reset.b_valid",  32'(b_valid),  32'd0);
        check("reset.a_count",  32'(a_count),  32'd0);
        check("reset.b_count",  32'(b_count),  32'd0);
        check("reset.a_data",   32'(a_data),   32'd0);
        check("reset.b_data",   32'(b_data),   32'd0);
        tick();

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ar, vecs[i].br);
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d.a_valid", i),  32'(a_valid),  32'(vecs[i].e_av));
            check($sformatf("vec%0d.a_data", i),   32'(a_data),   32'(vecs[i].e_ad));
            check($sformatf("vec%0d.a_count", i),  32'(a_count),  32'(vecs[i].e_ac));
            check($sformatf("vec%0d.b_valid", i),  32'(b_valid),  32'(vecs[i].e_bv));
            check($sformatf("vec%0d.b_data", i),   32'(b_data),   32'(vecs[i].e_bd));
            check($sformatf("vec%0d.b_count", i),  32'(b_count),  32'(vecs[i].e_bc));
            tick();
        end

        // Wrap-around streaming into B with a toggling consumer.
        idx = 0;
        cyc = 0;
        brt = 1'b0;
        while ((idx < 16 || rx.size() < 16) && cyc < 200) begin
            apply(idx < 16, 1'b1, 8'(idx), 1'b0, brt);
            check_model("wrap");
            check("wrap.b_count_le_depth", 32'(b_count <= 2'd2), 32'd1);
            check("wrap.a_valid_idle",     32'(a_valid),         32'd0);
            if (b_valid && brt) rx.push_back(b_data);
            if (idx < 16 && in_ready) idx++;
            tick();
            brt = ~brt;
            cyc++;
        end
        check("wrap.no_timeout", 32'(cyc < 200), 32'd1);
        check("wrap.received",   32'(rx.size()), 32'd16);
        for (int i = 0; i < rx.size(); i++) begin
            check($sformatf("wrap.order%0d", i), 32'(rx[i]), 32'(i));
        end

        // Asynchronous reset mid-cycle with both branches full.
        apply(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0); tick();
        apply(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0); tick();
        apply(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0); tick();
        apply(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0); tick();
        apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_model("prerst");
        check("prerst.a_count", 32'(a_count), 32'd2);
        check("prerst.b_count", 32'(b_count), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.a_valid", 32'(a_valid), 32'd0);
        check("midrst.b_valid", 32'(b_valid), 32'd0);
        check("midrst.a_count", 32'(a_count), 32'd0);
        check("midrst.b_count", 32'(b_count), 32'd0);
        check("midrst.a_data",  32'(a_data),  32'd0);
        check("midrst.b_data",  32'(b_data),  32'd0);
        qa.delete();
        qb.delete();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        apply(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        check_model("postrst.push");
        tick();
        apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("postrst.a_valid", 32'(a_valid), 32'd1);
        check("postrst.a_data",  32'(a_data),  32'h77);
        check("postrst.a_count", 32'(a_count), 32'd1);
        check("postrst.b_valid", 32'(b_valid), 32'd0);
        tick();
        apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_model("postrst.pop");
        tick();
        apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("postrst.a_empty", 32'(a_valid), 32'd0);
        tick();

        // Randomized traffic; a stalled input offer is held stable.
        hv = 1'b0;
        hs = 1'b0;
        hd = 8'h00;
        last_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!(hv && !last_rdy)) begin
                hv = ($urandom_range(0, 3) != 0);
                hs = 1'($urandom_range(0, 1));
                hd = 8'($urandom);
            end
            apply(hv, hs, hd, ($urandom_range(0, 3) < (i % 4)), ($urandom_range(0, 3) < ((i / 4) % 4)));
            check_model($sformatf("rand%0d", i));
            last_rdy = in_ready;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
